// File: rtl/sat_sub_serial_pkg.sv
// Shared definitions for the nibble-serial saturating subtractor:
// mode encodings, FSM state encoding and saturation constants.
package sat_sub_serial_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP  = 2'b00,
      MODE_SAT16 = 2'b01,
      MODE_SAT4  = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic [15:0] SAT16_POS = 16'h7FFF;
   localparam logic [15:0] SAT16_NEG = 16'h8000;
   localparam logic [3:0]  SAT4_POS  = 4'h7;
   localparam logic [3:0]  SAT4_NEG  = 4'h8;

   // Mode 11 is unassigned and behaves exactly like wrap.
   function automatic mode_e normalize_mode(input logic [1:0] m);
      case (m)
         MODE_SAT16: return MODE_SAT16;
         MODE_SAT4:  return MODE_SAT4;
         default:    return MODE_WRAP;
      endcase
   endfunction

endpackage

// File: rtl/sat_sub_serial_sub_nibble.sv
// Combinational 4-bit subtract slice: d = a + nb + cin, where nb is the
// already-inverted subtrahend nibble. vn flags signed overflow of the nibble.
module sub_nibble (
   input  logic [3:0] a,
   input  logic [3:0] nb,
   input  logic       cin,
   output logic [3:0] d,
   output logic       cout,
   output logic       vn
);

   logic [4:0] sum;

   // Add with carry-in; the fifth bit is the carry (inverse borrow) out.
   always_comb begin
      sum  = {1'b0, a} + {1'b0, nb} + {4'b0, cin};
      d    = sum[3:0];
      cout = sum[4];
      // Operand signs differ when a[3] equals the inverted subtrahend sign.
      vn   = (a[3] == nb[3]) & (sum[3] != a[3]);
   end

endmodule

// File: rtl/sat_sub_serial.sv
// Nibble-serial saturating subtractor Diff = A - B with valid/ready on both
// sides. One nibble is processed per cycle, LSB first; the carry chain is
// held in a register between cycles.
module sat_sub_serial
   import sat_sub_serial_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] Diff,
   output logic                 Z,
   output logic                 N,
   output logic                 V
);

   localparam int W     = 4 * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);
   // Full-width saturation limits; equal to SAT16_POS/SAT16_NEG at 16 bits.
   localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

   state_e           state, next_state;
   mode_e            mode_r;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     a_sh, nb_sh, res;
   logic             carry;
   logic             accept, step, last;

   logic [3:0]   nib_raw, nib_w;
   logic         cin, cout, vn;
   logic [W-1:0] full, diff_fin;
   logic         v_fin;

   assign last = (cnt == LAST_CNT);

   sub_nibble u_slice (
      .a    (a_sh[3:0]),
      .nb   (nb_sh[3:0]),
      .cin  (cin),
      .d    (nib_raw),
      .cout (cout),
      .vn   (vn)
   );

   // Slice carry-in, per-nibble saturation and final-result selection.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
      cin      = (mode_r == MODE_SAT4) ? 1'b1 : carry;
      nib_w    = nib_raw;
      if ((mode_r == MODE_SAT4) && vn)
         nib_w = a_sh[3] ? SAT4_NEG : SAT4_POS;
      full     = {nib_w, res[W-1:4]};
      // On the last nibble the slice overflow is exactly the full-width V.
      diff_fin = full;
      if ((mode_r == MODE_SAT16) && vn)
         diff_fin = a_sh[3] ? SAT_NEG : SAT_POS;
      v_fin    = (mode_r != MODE_SAT4) & vn;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (last) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand capture, nibble shifting, carry chain and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: operand and carry registers are reset too, so an aborted operation leaves no residue.
         a_sh   <= '0;
         nb_sh  <= '0;
         res    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         mode_r <= MODE_WRAP;
         Diff   <= '0;
         Z      <= 1'b0;
         N      <= 1'b0;
         V      <= 1'b0;
      end else if (accept) begin
         a_sh   <= A;
         nb_sh  <= ~B;
         carry  <= 1'b1;
         cnt    <= '0;
         mode_r <= normalize_mode(mode);
      end else if (step) begin
         a_sh  <= a_sh >> 4;
         nb_sh <= nb_sh >> 4;
         carry <= cout;
         cnt   <= cnt + 1'b1;
         res   <= full;
         if (last) begin
            Diff <= diff_fin;
            Z    <= (diff_fin == '0);
            N    <= diff_fin[W-1];
            V    <= v_fin;
         end
      end
   end

endmodule

// File: tb/tb_sat_sub_serial.sv
// Self-checking bench for sat_sub_serial: table-driven vectors plus
// hand-written backpressure and mid-operation reset sequences.
module tb_sat_sub_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A, B;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Diff;
   logic        Z, N, V;

   int n_cmp  = 0;
   int n_fail = 0;

   sat_sub_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Z         (Z),
      .N         (N),
      .V         (V)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  m;
      logic [15:0] diff;
      logic        z;
      logic        n;
      logic        v;
   } vec_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one operation; returns edges from accept until out_valid seen.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, output int lat);
      A = a; B = b; mode = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom); mode = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input vec_t e);
      check({tag, " diff"}, Diff, e.diff);
      check({tag, " z"}, 16'(Z), 16'(e.z));
      check({tag, " n"}, 16'(N), 16'(e.n));
      check({tag, " v"}, 16'(V), 16'(e.v));
   endtask

   vec_t vecs[8];
   vec_t e;
   int   lat;
   logic [15:0] held;

   initial begin
      vecs[0] = '{16'h0005, 16'h0003, 2'b00, 16'h0002, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h8000, 16'h0001, 2'b00, 16'h7FFF, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{16'h7FFF, 16'hFFFF, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h0001, 2'b01, 16'h8000, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{16'h7081, 16'h9F12, 2'b10, 16'h718F, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'h8888, 16'h1111, 2'b10, 16'h8888, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h0001, 2'b11, 16'h7FFF, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{16'h0010, 16'h0020, 2'b01, 16'hFFF0, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; mode = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 16'(in_ready), 16'd1);
      check("reset out_valid", 16'(out_valid), 16'd0);
      check_result("reset", '{16'h0, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0});
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         check({tag, " in_ready"}, 16'(in_ready), 16'd1);
         run_op(vecs[i].a, vecs[i].b, vecs[i].m, lat);
         check({tag, " latency"}, 16'(lat), 16'd4);
         check_result(tag, vecs[i]);
         release_result();
         check({tag, " out_valid cleared"}, 16'(out_valid), 16'd0);
         check({tag, " diff retained"}, Diff, vecs[i].diff);
      end

      // Zero result held under backpressure while in_valid pulses.
      e = '{16'h1234, 16'h1234, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0};
      run_op(e.a, e.b, e.m, lat);
      check("bp latency", 16'(lat), 16'd4);
      check_result("bp", e);
      for (int k = 0; k < 3; k++) begin
         A = 16'hFFFF - 16'(k); B = 16'h0001; mode = 2'b00;
         in_valid = (k != 1);
         @(posedge clk); #1;
         check($sformatf("bp hold%0d diff", k), Diff, 16'h0000);
         check($sformatf("bp hold%0d z", k), 16'(Z), 16'd1);
         check($sformatf("bp hold%0d out_valid", k), 16'(out_valid), 16'd1);
         check($sformatf("bp hold%0d in_ready", k), 16'(in_ready), 16'd0);
      end
      in_valid = 1'b0;
      release_result();
      check("bp in_ready after release", 16'(in_ready), 16'd1);
      check("bp out_valid after release", 16'(out_valid), 16'd0);
      held = Diff;
      check("bp diff after release", held, 16'h0000);

      // Reset two edges after accept drops the operation.
      A = 16'h1111; B = 16'h0001; mode = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst in_ready", 16'(in_ready), 16'd1);
      check("rst out_valid", 16'(out_valid), 16'd0);
      check_result("rst", '{16'h0, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0});
      e = '{16'h0003, 16'h0005, 2'b00, 16'hFFFE, 1'b0, 1'b1, 1'b0};
      run_op(e.a, e.b, e.m, lat);
      check("post-rst latency", 16'(lat), 16'd4);
      check_result("post-rst", e);
      release_result();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
